// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: binarised conv/FC weight source answering the accelerator's weight requests
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_wr_*              host preload port: one bit per cycle into the bank chosen by i_wr_sel
//                       (0 = conv A, 1 = conv B, 2..11 = FC class 0..9, 12..15 ignored)
//   i_rewind            returns every read pointer to 0, memories untouched
//   i_weight_en_0/1     conv requests, answered on o_weight_conv_in one cycle later
//   i_fc_ivalid         FC request, answered on o_weight_fc_out (bit k = class k) one cycle later
//   o_fc_wrap           pulses with the last FC bit of a pass
//   o_err               only when WEIGHT_STREAM_CHK_EN is defined: sticky misuse flag
module bnn_weight_streamer #(
    parameter int CONV_TAPS   = 9,
    parameter int CONV_B_LEN  = 72,
    parameter int FC_LEN      = 1352,
    parameter int NUM_CLASSES = 10,
    parameter int AW          = 11
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [3:0]             i_wr_sel,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic                   i_wr_data,
    input  logic                   i_rewind,
    input  logic                   i_weight_en_0,
    input  logic                   i_weight_en_1,
    input  logic                   i_fc_ivalid,
    output logic                   o_weight_conv_in,
    output logic [NUM_CLASSES-1:0] o_weight_fc_out,
`ifdef WEIGHT_STREAM_CHK_EN
    output logic                   o_fc_wrap,
    output logic                   o_err
`else
    output logic                   o_fc_wrap
`endif
);
    localparam int A_LEN = 2 * CONV_TAPS;
    localparam int AAW   = $clog2(A_LEN);
    localparam int BAW   = $clog2(CONV_B_LEN);
    localparam int FAW   = $clog2(FC_LEN);
    localparam int CW    = $clog2(A_LEN + 1);
    localparam logic [CW-1:0]  L_TAPS   = CW'(CONV_TAPS);
    localparam logic [CW-1:0]  L_A_LEN  = CW'(A_LEN);
    localparam logic [BAW-1:0] L_B_LAST = BAW'(CONV_B_LEN - 1);
    localparam logic [FAW-1:0] L_F_LAST = FAW'(FC_LEN - 1);
    localparam logic [AW-1:0]  L_WA     = AW'(A_LEN);
    localparam logic [AW-1:0]  L_WB     = AW'(CONV_B_LEN);
    localparam logic [AW-1:0]  L_WF     = AW'(FC_LEN);

    logic [A_LEN-1:0]       r_mem_a;
    logic [CONV_B_LEN-1:0]  r_mem_b;
    logic [FC_LEN-1:0]      r_mem_fc [NUM_CLASSES];
    logic [CW-1:0]          r_conv_cnt;
    logic [BAW-1:0]         r_convb_ptr;
    logic [FAW-1:0]         r_fc_ptr;
    logic                   r_conv_out;
    logic [NUM_CLASSES-1:0] r_fc_out;
    logic                   r_fc_wrap;
    logic                   w_a_hit;
    logic                   w_conv_req;
    logic                   w_fc_last;
    logic [NUM_CLASSES-1:0] w_fc_bits;

    // Memories are never reset so preloaded weights survive rst and rewind.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && i_wr_sel == 4'd0 && i_wr_addr < L_WA) r_mem_a[i_wr_addr[AAW-1:0]] <= i_wr_data;
        if (i_wr_en && i_wr_sel == 4'd1 && i_wr_addr < L_WB) r_mem_b[i_wr_addr[BAW-1:0]] <= i_wr_data;
        for (int k = 0; k < NUM_CLASSES; k++)
            if (i_wr_en && i_wr_sel == 4'(k + 2) && i_wr_addr < L_WF) r_mem_fc[k][i_wr_addr[FAW-1:0]] <= i_wr_data;
    end

    // Phase 0 may consume only the first kernel, phase 1 both; both read bank A, so one hit term suffices.
    assign w_a_hit    = (i_weight_en_0 && r_conv_cnt < L_TAPS) || (i_weight_en_1 && r_conv_cnt < L_A_LEN);
    assign w_conv_req = i_weight_en_0 || i_weight_en_1;
    assign w_fc_last  = r_fc_ptr == L_F_LAST;

    always_comb begin
        w_fc_bits = '0;
        for (int k = 0; k < NUM_CLASSES; k++) w_fc_bits[k] = r_mem_fc[k][r_fc_ptr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conv_cnt  <= '0;
            r_convb_ptr <= '0;
            r_fc_ptr    <= '0;
            r_conv_out  <= 1'b0;
            r_fc_out    <= '0;
            r_fc_wrap   <= 1'b0;
        end else if (i_rewind) begin
            r_conv_cnt  <= '0;
            r_convb_ptr <= '0;
            r_fc_ptr    <= '0;
            r_fc_wrap   <= 1'b0;
        end else begin
            r_fc_wrap <= i_fc_ivalid && w_fc_last;
            if (w_a_hit) begin
                r_conv_out <= r_mem_a[r_conv_cnt[AAW-1:0]];
                r_conv_cnt <= r_conv_cnt + 1'b1;
            end else if (w_conv_req) begin
                r_conv_out  <= r_mem_b[r_convb_ptr];
                r_convb_ptr <= (r_convb_ptr == L_B_LAST) ? '0 : r_convb_ptr + 1'b1;
            end
            if (i_fc_ivalid) begin
                r_fc_out <= w_fc_bits;
                r_fc_ptr <= w_fc_last ? '0 : r_fc_ptr + 1'b1;
            end
        end
    end

    assign o_weight_conv_in = r_conv_out;
    assign o_weight_fc_out  = r_fc_out;
    assign o_fc_wrap        = r_fc_wrap;

`ifdef WEIGHT_STREAM_CHK_EN
    logic r_wrapped;
    logic r_err;

    // r_wrapped remembers a completed FC pass not yet acknowledged by rewind.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_rewind) begin
            r_wrapped <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (i_fc_ivalid && w_fc_last) r_wrapped <= 1'b1;
            if ((i_fc_ivalid && w_fc_last && r_wrapped) || (i_wr_en && (w_conv_req || i_fc_ivalid))) r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif
endmodule

// File: tb/tb_bnn_weight_streamer.sv
// tb_bnn_weight_streamer: directed self-checking bench for bnn_weight_streamer
module tb_bnn_weight_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_sel = '0;
    logic [10:0] wr_addr = '0;
    logic        wr_data = 1'b0;
    logic        rewind = 1'b0;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic        fcv = 1'b0;
    logic        conv;
    logic [9:0]  fc;
    logic        wrap;
`ifdef WEIGHT_STREAM_CHK_EN
    logic        err;
`endif
    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] a_pat = 18'h2AAAA;
    logic [71:0] b_pat = 72'hA53C960FE17D28B4C3;

    always #5 clk = ~clk;

    bnn_weight_streamer dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rewind(rewind), .i_weight_en_0(en0), .i_weight_en_1(en1),
        .i_fc_ivalid(fcv), .o_weight_conv_in(conv), .o_weight_fc_out(fc), .o_fc_wrap(wrap)
`ifdef WEIGHT_STREAM_CHK_EN
        , .o_err(err)
`endif
    );

    function automatic logic fc_bit(int k, int i);
        return ((i * (k + 3) + k) % 5) < 2;
    endfunction

    function automatic logic [9:0] fc_exp(int i);
        logic [9:0] v;
        for (int k = 0; k < 10; k++) v[k] = fc_bit(k, i);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic e0, input logic e1, input logic f, input logic rw);
        en0 = e0; en1 = e1; fcv = f; rewind = rw;
        tick();
        en0 = 1'b0; en1 = 1'b0; fcv = 1'b0; rewind = 1'b0;
    endtask

    task automatic wr(input int sel, input int addr, input logic d);
        wr_en = 1'b1; wr_sel = 4'(sel); wr_addr = 11'(addr); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++; if (conv !== 1'b0) begin n_fail++; $display("FAIL reset_conv: got %b want 0", conv); end
        n_tests++; if (fc !== 10'd0) begin n_fail++; $display("FAIL reset_fc: got %b want 0", fc); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
`ifdef WEIGHT_STREAM_CHK_EN
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    endtask

    task automatic load_all;
        for (int i = 0; i < 18; i++) wr(0, i, a_pat[i]);
        for (int i = 0; i < 72; i++) wr(1, i, b_pat[i]);
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < 1352; i++) wr(k + 2, i, fc_bit(k, i));
        // out-of-range addresses that alias bit 0 if the range check is missing
        wr(0, 32, ~a_pat[0]);
        wr(1, 128, ~b_pat[0]);
        wr(12, 0, 1'b1);
    endtask

    task automatic test_conv;
        for (int i = 0; i < 9; i++) begin
            req(1'b1, 1'b0, 1'b0, 1'b0);
            n_tests++; if (conv !== a_pat[i]) begin n_fail++; $display("FAIL conv_a0[%0d]: got %b want %b", i, conv, a_pat[i]); end
        end
        for (int i = 9; i < 18; i++) begin
            req(1'(i % 2), 1'b1, 1'b0, 1'b0);
            n_tests++; if (conv !== a_pat[i]) begin n_fail++; $display("FAIL conv_a1[%0d]: got %b want %b", i, conv, a_pat[i]); end
        end
        for (int j = 0; j < 80; j++) begin
            req(1'b0, 1'b1, 1'b0, 1'b0);
            n_tests++; if (conv !== b_pat[j % 72]) begin n_fail++; $display("FAIL conv_b[%0d]: got %b want %b", j, conv, b_pat[j % 72]); end
        end
        tick(); tick(); tick();
        n_tests++; if (conv !== b_pat[7]) begin n_fail++; $display("FAIL conv_hold: got %b want %b", conv, b_pat[7]); end
        req(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++; if (conv !== b_pat[8]) begin n_fail++; $display("FAIL conv_en0_b: got %b want %b", conv, b_pat[8]); end
    endtask

    task automatic test_fc;
        for (int i = 0; i < 1352; i++) begin
            req(1'b0, 1'b0, 1'b1, 1'b0);
            n_tests++; if (fc !== fc_exp(i)) begin n_fail++; $display("FAIL fc[%0d]: got %b want %b", i, fc, fc_exp(i)); end
            n_tests++; if (wrap !== (i == 1351)) begin n_fail++; $display("FAIL fc_wrap[%0d]: got %b want %b", i, wrap, i == 1351); end
        end
        tick();
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL fc_wrap_pulse: got %b want 0", wrap); end
        req(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL fc_after_wrap: got %b want %b", fc, fc_exp(0)); end
    endtask

    task automatic test_mixed;
        req(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++; if (conv !== b_pat[8]) begin n_fail++; $display("FAIL mix_rw_conv: got %b want %b", conv, b_pat[8]); end
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL mix_rw_fc: got %b want %b", fc, fc_exp(0)); end
        req(1'b1, 1'b0, 1'b1, 1'b0);
        n_tests++; if (conv !== a_pat[0]) begin n_fail++; $display("FAIL mix1_conv: got %b want %b", conv, a_pat[0]); end
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL mix1_fc: got %b want %b", fc, fc_exp(0)); end
        tick(); tick();
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL mix_gap_fc: got %b want %b", fc, fc_exp(0)); end
        req(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++; if (conv !== a_pat[1]) begin n_fail++; $display("FAIL mix2_conv: got %b want %b", conv, a_pat[1]); end
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL mix2_fc_hold: got %b want %b", fc, fc_exp(0)); end
        req(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (fc !== fc_exp(1)) begin n_fail++; $display("FAIL mix3_fc: got %b want %b", fc, fc_exp(1)); end
        n_tests++; if (conv !== a_pat[1]) begin n_fail++; $display("FAIL mix3_conv_hold: got %b want %b", conv, a_pat[1]); end
        req(1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++; if (conv !== a_pat[2]) begin n_fail++; $display("FAIL mix4_conv: got %b want %b", conv, a_pat[2]); end
        n_tests++; if (fc !== fc_exp(2)) begin n_fail++; $display("FAIL mix4_fc: got %b want %b", fc, fc_exp(2)); end
    endtask

    task automatic test_rewind;
        req(1'b1, 1'b0, 1'b1, 1'b1);
        n_tests++; if (conv !== a_pat[2]) begin n_fail++; $display("FAIL rw_conv_hold: got %b want %b", conv, a_pat[2]); end
        n_tests++; if (fc !== fc_exp(2)) begin n_fail++; $display("FAIL rw_fc_hold: got %b want %b", fc, fc_exp(2)); end
        req(1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++; if (conv !== a_pat[1]) begin n_fail++; $display("FAIL rw_conv_restart: got %b want %b", conv, a_pat[1]); end
        req(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL rw_fc_restart: got %b want %b", fc, fc_exp(0)); end
        req(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1351; i++) req(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (fc !== fc_exp(1350)) begin n_fail++; $display("FAIL rw_fc_1350: got %b want %b", fc, fc_exp(1350)); end
        req(1'b0, 1'b0, 1'b1, 1'b1);
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rw_no_wrap: got %b want 0", wrap); end
        n_tests++; if (fc !== fc_exp(1350)) begin n_fail++; $display("FAIL rw_last_hold: got %b want %b", fc, fc_exp(1350)); end
        req(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL rw_last_restart: got %b want %b", fc, fc_exp(0)); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rw_restart_wrap: got %b want 0", wrap); end
    endtask

    task automatic test_rst_mid;
        req(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 500; i++) req(i < 3, 1'b0, 1'b1, 1'b0);
        n_tests++; if (fc !== fc_exp(499)) begin n_fail++; $display("FAIL rst_pre_fc: got %b want %b", fc, fc_exp(499)); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (conv !== 1'b0) begin n_fail++; $display("FAIL rst_mid_conv: got %b want 0", conv); end
        n_tests++; if (fc !== 10'd0) begin n_fail++; $display("FAIL rst_mid_fc: got %b want 0", fc); end
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wrap: got %b want 0", wrap); end
        req(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (fc !== fc_exp(0)) begin n_fail++; $display("FAIL rst_mid_fc0: got %b want %b", fc, fc_exp(0)); end
        req(1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++; if (conv !== a_pat[1]) begin n_fail++; $display("FAIL rst_mid_conv1: got %b want %b", conv, a_pat[1]); end
    endtask

    task automatic test_rw_same;
        req(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef WEIGHT_STREAM_CHK_EN
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_idle: got %b want 0", err); end
`endif
        for (int i = 0; i < 18; i++) req(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (conv !== a_pat[17]) begin n_fail++; $display("FAIL rw_same_a17: got %b want %b", conv, a_pat[17]); end
        wr_en = 1'b1; wr_sel = 4'd1; wr_addr = 11'd0; wr_data = ~b_pat[0]; en1 = 1'b1;
        tick();
        wr_en = 1'b0; en1 = 1'b0;
        n_tests++; if (conv !== b_pat[0]) begin n_fail++; $display("FAIL rw_same_old: got %b want %b", conv, b_pat[0]); end
`ifdef WEIGHT_STREAM_CHK_EN
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wr_serve: got %b want 1", err); end
`endif
        req(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) req(1'b0, 1'b1, 1'b0, 1'b0);
        req(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (conv !== ~b_pat[0]) begin n_fail++; $display("FAIL rw_same_new: got %b want %b", conv, ~b_pat[0]); end
    endtask

    initial begin
        test_reset();
        load_all();
        test_conv();
        test_fc();
        test_mixed();
        test_rewind();
        test_rst_mid();
        test_rw_same();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
